// File: rtl/adder_issue_stage.sv
// rtl/adder_issue_stage.sv - clocked, back-pressured operand front end for a combinational adder
//
// Buffers operand pairs in a DEPTH-entry FIFO. Each pair is issued to an
// external combinational adder. The adder result and its carry-out are
// captured and then offered downstream over a valid/ready handshake.
//
// Optional build macro: ADDER_ISSUE_STATS_EN adds the ovf_count output.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand pair handshake; in_ready = FIFO not full
//   in_a, in_b           operand pair
//   add_a, add_b         registered operands driven to the adder
//   add_result           adder sum (combinational from add_a/add_b)
//   out_valid/out_ready  result handshake
//   out_sum, out_carry   captured sum and unsigned carry-out
//   fifo_count           current FIFO occupancy
//   ovf_count            (ADDER_ISSUE_STATS_EN) saturating count of carried results

module adder_issue_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH-1:0]           add_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic                       out_carry,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
`ifdef ADDER_ISSUE_STATS_EN
    ,
    output logic [15:0]                ovf_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_carry_q, out_carry_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // A full FIFO refuses the push even if a pop frees a slot this cycle.
    assign push  = in_valid && !full;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // For unsigned wrap-around addition the sum is below an
                // operand exactly when the addition carried out.
                out_sum_d   = add_result;
                out_carry_d = (add_result < add_a_q);
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        add_a_d  = pop  ? mem_a_q[rd_ptr_q] : add_a_q;
        add_b_d  = pop  ? mem_b_q[rd_ptr_q] : add_b_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            add_a_q     <= '0;
            add_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
        end
    end

`ifdef ADDER_ISSUE_STATS_EN
    logic [15:0] ovf_count_q, ovf_count_d;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (out_valid_q && out_ready && out_carry_q && (ovf_count_q != 16'hFFFF)) begin
            ovf_count_d = ovf_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
`endif

    assign in_ready   = !full;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_carry  = out_carry_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_adder_issue_stage.sv
// tb/tb_adder_issue_stage.sv - self-checking bench for adder_issue_stage
module tb_adder_issue_stage;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic [CNT_W-1:0] fifo_count;
`ifdef ADDER_ISSUE_STATS_EN
    logic [15:0]      ovf_count;
    int               model_ovf = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Expected results in issue order: {carry, sum} as a WIDTH+1 bit sum.
    logic [WIDTH:0] exp_q [$];

    always #5 clk = ~clk;

    // Stand-in for the combinational adder downstream of the stage.
    assign add_result = add_a + add_b;

    adder_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_carry  (out_carry),
        .fifo_count (fifo_count)
`ifdef ADDER_ISSUE_STATS_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Scoreboard: inputs only change just after a rising edge, so the values
    // seen on the falling edge are those the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
`ifdef ADDER_ISSUE_STATS_EN
            model_ovf = 0;
`endif
        end else begin
            check("ready_vs_count", 32'(in_ready), 32'(fifo_count < CNT_W'(DEPTH)));
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_result", 32'd1, 32'd0);
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    check("sb_sum", 32'(out_sum), 32'(e[WIDTH-1:0]));
                    check("sb_carry", 32'(out_carry), 32'(e[WIDTH]));
`ifdef ADDER_ISSUE_STATS_EN
                    if (e[WIDTH] && model_ovf < 65535) model_ovf++;
`endif
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single pair: accept E0, pop E1, capture E2.
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd4;
        step();
        in_valid = 1'b0;
        check("lat_count_e0", 32'(fifo_count), 32'd1);
        check("lat_valid_e0", 32'(out_valid), 32'd0);
        step();
        check("lat_count_e1", 32'(fifo_count), 32'd0);
        check("lat_add_a_e1", 32'(add_a), 32'd3);
        check("lat_valid_e1", 32'(out_valid), 32'd0);
        step();
        check("lat_valid_e2", 32'(out_valid), 32'd1);
        check("lat_sum", 32'(out_sum), 32'd7);
        check("lat_carry", 32'(out_carry), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("lat_valid_done", 32'(out_valid), 32'd0);

        // Carry case.
        in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15;
        step();
        in_valid = 1'b0;
        wait_valid("ovf");
        check("ovf_sum", 32'(out_sum), 32'd14);
        check("ovf_carry", 32'(out_carry), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`ifdef ADDER_ISSUE_STATS_EN
        check("ovf_count_1", 32'(ovf_count), 32'd1);
`endif

        // Fill under back-pressure, then drain in order.
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_a = 4'(k); in_b = 4'(k);
            step();
        end
        check("fill_count", 32'(fifo_count), 32'd4);
        check("fill_ready", 32'(in_ready), 32'd0);
        check("fill_add_a", 32'(add_a), 32'd1);
        in_a = 4'd6; in_b = 4'd6;
        step();
        in_valid = 1'b0;
        check("full_ignore_count", 32'(fifo_count), 32'd4);
        check("full_ignore_add_a", 32'(add_a), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_valid($sformatf("drain%0d", k));
            check($sformatf("drain%0d_sum", k), 32'(out_sum), 32'(2 * k));
            step();
        end
        out_ready = 1'b0;
        step();
        check("drain_valid_low", 32'(out_valid), 32'd0);
        check("drain_count", 32'(fifo_count), 32'd0);

        // Result held stable under back-pressure.
        in_valid = 1'b1; in_a = 4'd0; in_b = 4'd0;
        step();
        in_valid = 1'b0;
        wait_valid("hold");
        for (int k = 0; k < 10; k++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), 32'd0);
            check("hold_add_a", 32'(add_a), 32'd0);
            check("hold_add_b", 32'(add_b), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset while holding a result with two pairs queued.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_a = 4'(9 + k); in_b = 4'(1 + k);
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(fifo_count), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        check("async_rst_add_a", 32'(add_a), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Back-to-back stream: one result every two cycles.
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd8;
        step();
        in_a = 4'd9; in_b = 4'd9;
        step();
        in_a = 4'd0; in_b = 4'd15;
        step();
        in_valid = 1'b0;
        check("strm0_valid", 32'(out_valid), 32'd1);
        check("strm0_sum", 32'(out_sum), 32'd15);
        check("strm0_carry", 32'(out_carry), 32'd0);
        step();
        check("strm_gap0", 32'(out_valid), 32'd0);
        step();
        check("strm1_valid", 32'(out_valid), 32'd1);
        check("strm1_sum", 32'(out_sum), 32'd2);
        check("strm1_carry", 32'(out_carry), 32'd1);
        step();
        check("strm_gap1", 32'(out_valid), 32'd0);
        step();
        check("strm2_valid", 32'(out_valid), 32'd1);
        check("strm2_sum", 32'(out_sum), 32'd15);
        check("strm2_carry", 32'(out_carry), 32'd0);
        step();

        // Random traffic against the scoreboard.
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 4'($urandom);
            in_b      = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) step();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        check("final_count", 32'(fifo_count), 32'd0);
        check("final_valid", 32'(out_valid), 32'd0);
`ifdef ADDER_ISSUE_STATS_EN
        check("final_ovf_count", 32'(ovf_count), 32'(model_ovf));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
